// File: rtl/pp_pkg.sv
// Shared types and defaults for the instruction prefetch buffer.
package pp_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    DROP
  } pf_state_e;

  localparam int          DEFAULT_DEPTH    = 4;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

endpackage

// File: rtl/prefetch_fifo.sv
// Synchronous show-ahead FIFO holding {pc_plus4, instr} pairs.
module prefetch_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rstb,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic [WIDTH-1:0] wdata,
  output logic [CW-1:0]    count,
  output logic [WIDTH-1:0] head
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    count_q;

  // Flush wins over push/pop; DEPTH is a power of two so pointers wrap naturally.
  always_ff @(posedge clk) begin
    if (rstb) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else if (flush) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count_q <= count_q + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (!rstb && !flush && push) mem[wr_ptr] <= wdata;
  end

  assign count = count_q;
  assign head  = (count_q != '0) ? mem[rd_ptr] : '0;

endmodule

// File: rtl/instr_prefetch.sv
// Sequential instruction prefetcher: one outstanding req/ack fetch feeding a
// show-ahead FIFO, with flush-and-refetch on a taken branch.
module instr_prefetch
  import pp_pkg::*;
#(
  parameter int                   DATA_WIDTH = 32,
  parameter int                   PC_WIDTH   = 32,
  parameter int                   DEPTH      = DEFAULT_DEPTH,
  parameter logic [PC_WIDTH-1:0]  RESET_PC   = PC_WIDTH'(DEFAULT_RESET_PC)
) (
  input  logic                     clk,
  input  logic                     rstb,
  output logic                     imem_req,
  output logic [PC_WIDTH-1:0]      imem_addr,
  input  logic                     imem_ack,
  input  logic [DATA_WIDTH-1:0]    imem_rdata,
  output logic                     instr_valid,
  output logic [DATA_WIDTH-1:0]    instr,
  output logic [PC_WIDTH-1:0]      pc_plus4,
  input  logic                     hold_if,
  input  logic                     redirect,
  input  logic [PC_WIDTH-1:0]      redirect_pc,
  output logic [$clog2(DEPTH):0]   fifo_count
);

  localparam int CW = $clog2(DEPTH) + 1;

  pf_state_e                      state_q, state_d;
  logic [PC_WIDTH-1:0]            fetch_pc_q, fetch_pc_d;
  logic [PC_WIDTH-1:0]            addr_d;
  logic                           req_d;
  logic [PC_WIDTH-1:0]            pc_inc;
  logic                           pop, push, room;
  logic [CW-1:0]                  count_q, count_next;
  logic [PC_WIDTH+DATA_WIDTH-1:0] head;

  assign pc_inc     = fetch_pc_q + PC_WIDTH'(4);
  assign pop        = instr_valid && !hold_if && !redirect;
  assign push       = (state_q == WAIT) && imem_ack && !redirect;
  assign count_next = redirect ? '0 : (count_q - CW'(pop) + CW'(push));
  assign room       = count_next < CW'(DEPTH);

  // A new request is only issued when the FIFO will have room for its response.
  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    req_d      = imem_req;
    addr_d     = imem_addr;

    if (push)     fetch_pc_d = pc_inc;
    if (redirect) fetch_pc_d = redirect_pc;

    case (state_q)
      IDLE: begin
        if (redirect) begin
          state_d = WAIT;
          req_d   = 1'b1;
          addr_d  = redirect_pc;
        end else if (room) begin
          state_d = WAIT;
          req_d   = 1'b1;
          addr_d  = fetch_pc_q;
        end
      end
      WAIT: begin
        if (imem_ack) begin
          if (redirect) begin
            addr_d = redirect_pc;
          end else if (room) begin
            addr_d = pc_inc;
          end else begin
            state_d = IDLE;
            req_d   = 1'b0;
          end
        end else if (redirect) begin
          state_d = DROP;
        end
      end
      DROP: begin
        // The stale response retires here; fetch_pc already holds the target.
        if (imem_ack) begin
          state_d = WAIT;
          req_d   = 1'b1;
          addr_d  = redirect ? redirect_pc : fetch_pc_q;
        end
      end
      default: begin
        state_d = IDLE;
        req_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rstb) begin
      state_q    <= IDLE;
      fetch_pc_q <= RESET_PC;
      imem_req   <= 1'b0;
      imem_addr  <= '0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      imem_req   <= req_d;
      imem_addr  <= addr_d;
    end
  end

  prefetch_fifo #(
    .WIDTH (PC_WIDTH + DATA_WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rstb  (rstb),
    .push  (push),
    .pop   (pop),
    .flush (redirect),
    .wdata ({pc_inc, imem_rdata}),
    .count (count_q),
    .head  (head)
  );

  assign fifo_count  = count_q;
  assign instr_valid = (count_q != '0);
  assign instr       = head[DATA_WIDTH-1:0];
  assign pc_plus4    = head[DATA_WIDTH +: PC_WIDTH];

endmodule

// File: tb/tb_instr_prefetch.sv
// Bench for instr_prefetch: directed scenarios plus randomized traffic checked
// against a queue-based model of the prefetch buffer.
module tb_instr_prefetch;

  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rstb;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] pc_plus4;
  logic        hold_if;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic [2:0]  fifo_count;

  always #5 clk = ~clk;

  instr_prefetch #(
    .DATA_WIDTH (32),
    .PC_WIDTH   (32),
    .DEPTH      (DEPTH),
    .RESET_PC   (RESET_PC)
  ) dut (
    .clk         (clk),
    .rstb        (rstb),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_rdata  (imem_rdata),
    .instr_valid (instr_valid),
    .instr       (instr),
    .pc_plus4    (pc_plus4),
    .hold_if     (hold_if),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .fifo_count  (fifo_count)
  );

  // Reference model: queue of {pc_plus4, instr}, the fetch pointer and the request in flight.
  logic [63:0] q[$];
  logic [31:0] m_fetch_pc;
  logic [31:0] m_req_addr;
  bit          m_req;
  bit          m_drop;
  bit          m_just_reset;

  int    checks = 0;
  int    passed = 0;
  int    cyc    = 0;
  string phase  = "init";
  int    mem_wait;
  int    mem_lat;
  bit    rand_lat;
  bit    found;
  logic [31:0] rpc;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'h5A5A_0F0F;
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs === exp) passed++;
    else $display("[TB] FAIL %s/%s cycle %0d: got 0x%0h, expected 0x%0h", phase, tag, cyc, obs, exp);
  endtask

  task automatic checkModel();
    logic [63:0] head;
    head = (q.size() != 0) ? q[0] : 64'h0;
    checkOutput("instr_valid", 64'(instr_valid), 64'(q.size() != 0));
    checkOutput("fifo_count", 64'(fifo_count), 64'(q.size()));
    checkOutput("instr", 64'(instr), 64'(head[31:0]));
    checkOutput("pc_plus4", 64'(pc_plus4), 64'(head[63:32]));
    checkOutput("imem_req", 64'(imem_req), 64'(m_req));
    if (m_req || m_just_reset) checkOutput("imem_addr", 64'(imem_addr), 64'(m_req_addr));
  endtask

  // One clock: check current outputs, drive inputs plus the memory response, advance the model.
  task automatic applyStimulus(input bit rst, input bit hold, input bit redir, input logic [31:0] rp);
    bit ack, req_seen, pop, accept;
    @(negedge clk);
    checkModel();
    req_seen    = imem_req;
    ack         = req_seen && (mem_wait >= mem_lat);
    rstb        = rst;
    hold_if     = hold;
    redirect    = redir;
    redirect_pc = rp;
    imem_ack    = ack;
    imem_rdata  = ack ? mem_word(imem_addr) : $urandom();
    @(posedge clk);
    cyc++;
    if (rst || ack || !req_seen) mem_wait = 0;
    else mem_wait++;
    if (ack && rand_lat) mem_lat = $urandom_range(0, 3);

    if (rst) begin
      q.delete();
      m_fetch_pc   = RESET_PC;
      m_req        = 0;
      m_drop       = 0;
      m_req_addr   = 32'h0;
      m_just_reset = 1;
    end else begin
      m_just_reset = 0;
      pop    = (q.size() != 0) && !hold && !redir;
      accept = m_req && ack && !m_drop && !redir;
      if (redir) q.delete();
      else begin
        if (pop) void'(q.pop_front());
        if (accept) q.push_back({m_fetch_pc + 32'd4, imem_rdata});
      end
      if (accept) m_fetch_pc = m_fetch_pc + 32'd4;
      if (redir) m_fetch_pc = rp;
      if (!m_req) begin
        if (redir || q.size() < DEPTH) begin
          m_req      = 1;
          m_req_addr = m_fetch_pc;
        end
      end else if (ack) begin
        if (redir || m_drop) begin
          m_req_addr = m_fetch_pc;
          m_drop     = 0;
        end else if (q.size() < DEPTH) m_req_addr = m_fetch_pc;
        else m_req = 0;
      end else if (redir) m_drop = 1;
    end
  endtask

  initial begin
    rstb = 1'b1; hold_if = 1'b0; redirect = 1'b0; redirect_pc = '0;
    imem_ack = 1'b0; imem_rdata = '0;
    mem_wait = 0; mem_lat = 0; rand_lat = 0;
    q.delete(); m_fetch_pc = RESET_PC; m_req = 0; m_drop = 0;
    m_req_addr = 32'h0; m_just_reset = 1;
    repeat (2) @(posedge clk);

    phase = "zero_wait";
    applyStimulus(1, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(0, 0, 0, 0);
      #1;
      checkOutput("seq_addr", 64'(imem_addr), 64'(i * 4));
      checkOutput("seq_valid", 64'(instr_valid), 64'(i > 0));
      if (i > 0) checkOutput("seq_pc4", 64'(pc_plus4), 64'(i * 4));
    end
    repeat (3) applyStimulus(0, 0, 0, 0);

    phase = "hold";
    repeat (10) applyStimulus(0, 1, 0, 0);
    #1;
    checkOutput("sat_count", 64'(fifo_count), 64'(DEPTH));
    checkOutput("sat_req", 64'(imem_req), 64'(0));
    repeat (8) applyStimulus(0, 0, 0, 0);

    phase = "drop";
    applyStimulus(1, 0, 0, 0);
    mem_lat = 3;
    found = 0;
    for (int i = 0; i < 60; i++) begin
      applyStimulus(0, 0, 0, 0);
      #1;
      if (imem_req && imem_addr == 32'h8 && mem_wait == 1) begin
        found = 1;
        break;
      end
    end
    checkOutput("find_req8", 64'(found), 64'(1));
    applyStimulus(0, 0, 1, 32'h100);
    for (int i = 0; i < 20; i++) begin
      applyStimulus(0, 0, 0, 0);
      #1;
      if (instr_valid) break;
    end
    checkOutput("redir_first_pc4", 64'(pc_plus4), 64'h104);

    phase = "redir_ack";
    mem_lat = 0;
    repeat (4) applyStimulus(0, 0, 0, 0);
    applyStimulus(0, 0, 1, 32'h200);
    #1;
    checkOutput("ra_count", 64'(fifo_count), 64'(0));
    checkOutput("ra_req", 64'(imem_req), 64'(1));
    checkOutput("ra_addr", 64'(imem_addr), 64'h200);
    repeat (4) applyStimulus(0, 0, 0, 0);

    phase = "mid_reset";
    mem_lat = 2;
    found = 0;
    for (int i = 0; i < 40; i++) begin
      applyStimulus(0, 1, 0, 0);
      #1;
      if (fifo_count == 3 && imem_req) begin
        found = 1;
        break;
      end
    end
    checkOutput("find_cnt3", 64'(found), 64'(1));
    applyStimulus(1, 1, 0, 0);
    #1;
    checkOutput("rst_req", 64'(imem_req), 64'(0));
    checkOutput("rst_addr", 64'(imem_addr), 64'(0));
    checkOutput("rst_valid", 64'(instr_valid), 64'(0));
    checkOutput("rst_instr", 64'(instr), 64'(0));
    checkOutput("rst_pc4", 64'(pc_plus4), 64'(0));
    checkOutput("rst_count", 64'(fifo_count), 64'(0));
    applyStimulus(0, 0, 0, 0);
    #1;
    checkOutput("post_rst_req", 64'(imem_req), 64'(1));
    checkOutput("post_rst_addr", 64'(imem_addr), 64'(RESET_PC));

    phase = "wrap";
    mem_lat = 0;
    applyStimulus(0, 0, 1, 32'hFFFF_FFFC);
    applyStimulus(0, 0, 0, 0);
    #1;
    checkOutput("wrap_valid", 64'(instr_valid), 64'(1));
    checkOutput("wrap_pc4", 64'(pc_plus4), 64'(0));
    checkOutput("wrap_instr", 64'(instr), 64'(mem_word(32'hFFFF_FFFC)));
    checkOutput("wrap_addr", 64'(imem_addr), 64'(0));
    repeat (3) applyStimulus(0, 0, 0, 0);

    phase = "random";
    rand_lat = 1;
    for (int i = 0; i < 600; i++) begin
      rpc = $urandom() & 32'hFFFF_FFFC;
      if ($urandom_range(0, 3) == 0) rpc = 32'hFFFF_FFF8;
      applyStimulus($urandom_range(0, 99) == 0, $urandom_range(0, 9) < 4,
                    $urandom_range(0, 19) == 0, rpc);
    end
    applyStimulus(0, 0, 0, 0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
